// File: rtl/req_queue8_pkg.sv
// Shared sizing constants for the 8-client request queue and its per-client slots.
package req_queue8_pkg;
  localparam int N     = 8;
  localparam int CNT_W = 3;
  localparam int AGE_W = 4;
  localparam int IDX_W = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'((1 << AGE_W) - 1);
endpackage

// File: rtl/req_slot.sv
// One client's pending-request counter plus its saturating wait-age counter.
module req_slot
  import req_queue8_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  logic grant,
  output logic req,
  output logic full,
  output logic starve,
  output logic drop
);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [AGE_W-1:0] age, age_next;

  assign req    = (cnt != '0);
  assign full   = (cnt == CNT_MAX);
  assign starve = (age == AGE_MAX);

  always_comb begin
    cnt_next = cnt;
    drop     = 1'b0;
    // A push and a grant in the same cycle cancel out.
    if (grant && !push) begin
      cnt_next = cnt - CNT_W'(1);
    end else if (push && !grant) begin
      if (cnt == CNT_MAX) drop = 1'b1;
      else                cnt_next = cnt + CNT_W'(1);
    end

    age_next = age;
    if (grant || (cnt_next == '0)) begin
      age_next = '0;
    end else if (req && (age != AGE_MAX)) begin
      age_next = age + AGE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      age <= '0;
    end else begin
      cnt <= cnt_next;
      age <= age_next;
    end
  end

endmodule

// File: rtl/req_queue8.sv
// Eight-client request queue: per-client counters feed a priority selector and
// the returned grant is validated, encoded and reported one cycle later.
module req_queue8
  import req_queue8_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     push,
  input  logic             stall,
  input  logic [N-1:0]     gnt,
  output logic [N-1:0]     req,
  output logic             en,
  output logic [N-1:0]     full,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             err,
  output logic [N-1:0]     starve
);

  // Grant handshake: en is the ready, gnt the valid. A grant is accepted only in a
  // cycle with en=1, gnt one-hot and req set for that client; anything else non-zero
  // on gnt is a protocol error and is ignored.
  logic           gnt_onehot;
  logic           accept;
  logic           bad_gnt;
  logic [N-1:0]   grant_vec;
  logic [N-1:0]   drop;
  logic [IDX_W-1:0] gnt_enc;

  assign en         = (|req) & ~stall;
  assign gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
  assign accept     = en && gnt_onehot && ((gnt & req) != '0);
  assign bad_gnt    = (gnt != '0) && !accept;
  assign grant_vec  = accept ? gnt : '0;

  always_comb begin
    gnt_enc = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_enc = gnt_enc | IDX_W'(i);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    req_slot u_slot (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push[i]),
      .grant   (grant_vec[i]),
      .req     (req[i]),
      .full    (full[i]),
      .starve  (starve[i]),
      .drop    (drop[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      err       <= 1'b0;
    end else begin
      gnt_valid <= accept;
      if (accept) gnt_idx <= gnt_enc;
      err       <= bad_gnt | (|drop);
    end
  end

endmodule

// File: tb/tb_req_queue8.sv
// Bench for req_queue8: directed scenarios then random traffic against a
// per-client count/age model built from the queue's rules.
module tb_req_queue8;

  logic       clock;
  logic       reset_n;
  logic [7:0] push;
  logic       stall;
  logic [7:0] gnt;
  logic [7:0] req;
  logic       en;
  logic [7:0] full;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       err;
  logic [7:0] starve;

  req_queue8 dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .stall     (stall),
    .gnt       (gnt),
    .req       (req),
    .en        (en),
    .full      (full),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .err       (err),
    .starve    (starve)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  int         m_cnt [8];
  int         m_age [8];
  logic [2:0] exp_q [$];

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_age[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_req",       32'(req),       32'h0);
    check_val("rst_en",        32'(en),        32'h0);
    check_val("rst_full",      32'(full),      32'h0);
    check_val("rst_starve",    32'(starve),    32'h0);
    check_val("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    check_val("rst_gnt_idx",   32'(gnt_idx),   32'h0);
    check_val("rst_err",       32'(err),       32'h0);
  endtask

  // driver: apply one cycle of inputs, check combinational outputs, clock, check pulses
  task automatic step(input logic [7:0] p, input logic s, input logic [7:0] g);
    logic [7:0] e_req, e_full, e_starve;
    logic       e_en, acc, dropped, gi;
    int         idx;
    logic [2:0] e_idx;
    push = p; stall = s; gnt = g;
    #1;
    for (int i = 0; i < 8; i++) begin
      e_req[i]    = (m_cnt[i] != 0);
      e_full[i]   = (m_cnt[i] == 7);
      e_starve[i] = (m_age[i] == 15);
    end
    e_en = (e_req != 8'h00) && !s;
    check_val("req",    32'(req),    32'(e_req));
    check_val("en",     32'(en),     32'(e_en));
    check_val("full",   32'(full),   32'(e_full));
    check_val("starve", 32'(starve), 32'(e_starve));

    acc = e_en && ($countones(g) == 1) && ((g & e_req) != 8'h00);
    dropped = 1'b0;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      gi = acc && g[i];
      if (gi) idx = i;
      if (gi && !p[i])            m_cnt[i] = m_cnt[i] - 1;
      else if (p[i] && !gi) begin
        if (m_cnt[i] == 7) dropped = 1'b1;
        else               m_cnt[i] = m_cnt[i] + 1;
      end
      if (gi || m_cnt[i] == 0) m_age[i] = 0;
      else if (e_req[i] && m_age[i] < 15) m_age[i] = m_age[i] + 1;
    end
    if (acc) exp_q.push_back(3'(idx));

    @(posedge clock);
    #1;
    check_val("gnt_valid", 32'(gnt_valid), 32'(acc));
    check_val("err", 32'(err), 32'(((g != 8'h00) && !acc) || dropped));
    if (acc) begin
      e_idx = exp_q.pop_front();
      if (gnt_valid) check_val("gnt_idx", 32'(gnt_idx), 32'(e_idx));
    end
  endtask

  initial begin
    logic [7:0] p, g;
    logic       s;
    int         r, lo;

    reset_n = 1'b0; push = '0; stall = 1'b0; gnt = '0;
    model_clear();
    #1;
    check_reset_outputs();
    #13 reset_n = 1'b1;   // release between edges
    @(posedge clock); #1;

    // three pushes to client 0, then idle: req=01, en=1, no err
    repeat (3) step(8'h01, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h00);
    // drain client 0 with exactly three grants
    repeat (3) step(8'h00, 1'b0, 8'h01);
    step(8'h00, 1'b0, 8'h00);

    // client 5 at count 2, one grant
    repeat (2) step(8'h20, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h20);

    // fill client 2, then overflow push, then push coinciding with grant
    repeat (7) step(8'h04, 1'b0, 8'h00);
    step(8'h04, 1'b0, 8'h00);
    step(8'h04, 1'b0, 8'h04);
    step(8'h00, 1'b0, 8'h00);

    // illegal grants: multi-hot, grant to empty client, grant under stall
    step(8'h01, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h06);
    step(8'h00, 1'b0, 8'h80);
    step(8'h00, 1'b1, 8'h01);
    step(8'h00, 1'b0, 8'h00);

    // client 3 starvation then recovery on grant
    step(8'h08, 1'b0, 8'h00);
    repeat (15) step(8'h00, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h08);
    step(8'h00, 1'b0, 8'h00);

    // grant leaves gnt_idx non-zero, then async reset between edges
    step(8'h40, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h40);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    #2 reset_n = 1'b1;
    step(8'h10, 1'b0, 8'h00);
    step(8'h00, 1'b0, 8'h10);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      p = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      s = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      lo = -1;
      for (int i = 7; i >= 0; i--) if (m_cnt[i] != 0) lo = i;
      if (r <= 4)                g = 8'(1 << $urandom_range(0, 7));
      else if (r <= 6)           g = 8'h00;
      else if (r == 7)           g = 8'($urandom);
      else if (lo >= 0)          g = 8'(1 << lo);
      else                       g = 8'h00;
      step(p, s, g);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
